// File: rtl/rptr_empty_fwft_if.sv
// Read-side bundle of the async FIFO: synchronized write pointer in, read pointer,
// memory read port, first-word-fall-through output handshake and status flags.
interface rptr_empty_fwft_if #(
  parameter int ADDRSIZE = 4,
  parameter int DATASIZE = 8
);
  logic [ADDRSIZE:0]   rq2_wptr;
  logic [ADDRSIZE:0]   rptr;
  logic [ADDRSIZE-1:0] raddr;
  logic                ren;
  logic [DATASIZE-1:0] rmem_data;
  logic [DATASIZE-1:0] rdata;
  logic                rvalid;
  logic                rready;
  logic                rempty;
  logic                raempty;
  logic [ADDRSIZE:0]   rlevel;

  modport master (
    input  rq2_wptr, rmem_data, rready,
    output rptr, raddr, ren, rdata, rvalid, rempty, raempty, rlevel
  );

  modport slave (
    output rq2_wptr, rmem_data, rready,
    input  rptr, raddr, ren, rdata, rvalid, rempty, raempty, rlevel
  );
endinterface

// File: rtl/rptr_empty_fwft.sv
// Async FIFO read-domain control: Gray read pointer, empty/almost-empty/level flags,
// and a 2-entry FWFT output buffer fed by a 1-cycle-latency memory read.
module rptr_empty_fwft #(
  parameter int ADDRSIZE     = 4,
  parameter int DATASIZE     = 8,
  parameter int AEMPTY_LEVEL = 2
) (
  input  logic              rclk,
  input  logic              rrst,
  rptr_empty_fwft_if.master rif
);
  localparam int PW = ADDRSIZE + 1;
  typedef logic [PW-1:0] ptr_t;

  ptr_t                rbin_q, rbin_d;
  ptr_t                rptr_q, rptr_d;
  ptr_t                rlevel_q, rlevel_d;
  ptr_t                wbin_s;
  ptr_t                rbnext;
  logic                rempty_q, rempty_d;
  logic                raempty_q, raempty_d;
  logic                inflight_q, inflight_d;
  logic [1:0]          held_q, held_d;
  logic [DATASIZE-1:0] head_q, head_d;
  logic [DATASIZE-1:0] tail_q, tail_d;
  logic                pop;
  logic                ren;
  logic [2:0]          occ_after;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    wbin_s = '0;
    for (int i = 0; i < PW; i++) begin
      wbin_s[i] = ^(rif.rq2_wptr >> i);
    end
  end

  always_comb begin
    pop       = (held_q != 2'd0) && rif.rready;
    // Entries occupied once this cycle's pop and returning read settle; a new read
    // is only issued if it will have a free slot when its data lands.
    occ_after = {1'b0, held_q} + {2'b00, inflight_q} - {2'b00, pop};
    ren       = ~rempty_q && (occ_after < 3'd2);

    rbnext    = rbin_q + {{ADDRSIZE{1'b0}}, ren};
    rbin_d    = rbnext;
    rptr_d    = (rbnext >> 1) ^ rbnext;
    rempty_d  = (rptr_d == rif.rq2_wptr);
    rlevel_d  = wbin_s - rbnext;
    raempty_d = (rlevel_d <= ptr_t'(AEMPTY_LEVEL));

    held_d     = occ_after[1:0];
    inflight_d = ren;

    head_d = head_q;
    tail_d = tail_q;
    if (pop) begin
      head_d = tail_q;
    end
    // A returning word lands in whichever slot is the tail after the pop.
    if (inflight_q) begin
      if ((held_q == 2'd0) || ((held_q == 2'd1) && pop)) begin
        head_d = rif.rmem_data;
      end else begin
        tail_d = rif.rmem_data;
      end
    end
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin_q     <= '0;
      rptr_q     <= '0;
      rempty_q   <= 1'b1;
      raempty_q  <= 1'b1;
      rlevel_q   <= '0;
      held_q     <= 2'd0;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      rbin_q     <= rbin_d;
      rptr_q     <= rptr_d;
      rempty_q   <= rempty_d;
      raempty_q  <= raempty_d;
      rlevel_q   <= rlevel_d;
      held_q     <= held_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  assign rif.rptr    = rptr_q;
  assign rif.raddr   = rbin_q[ADDRSIZE-1:0];
  assign rif.ren     = ren;
  assign rif.rdata   = head_q;
  assign rif.rvalid  = (held_q != 2'd0);
  assign rif.rempty  = rempty_q;
  assign rif.raempty = raempty_q;
  assign rif.rlevel  = rlevel_q;
endmodule

// File: tb/tb_rptr_empty_fwft.sv
// Bench for rptr_empty_fwft: directed timing steps plus a randomized wrap-around run
// scored against an ordered word list and a behavioural memory model.
module tb_rptr_empty_fwft;
  logic rclk;
  logic rrst;
  int   checks;
  int   failures;
  int   wcount;
  int   popped;
  int   nren;
  int   target;
  int   n;
  bit   mon_en;
  bit   prev_hold;
  bit   seen_wrap;
  logic [7:0] prev_data;
  logic [7:0] mem   [16];
  logic [7:0] wdata [256];

  rptr_empty_fwft_if #(.ADDRSIZE(4), .DATASIZE(8)) rif ();

  rptr_empty_fwft #(.ADDRSIZE(4), .DATASIZE(8), .AEMPTY_LEVEL(2)) dut (
    .rclk (rclk),
    .rrst (rrst),
    .rif  (rif)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  // Synchronous-read memory: data valid one cycle after ren.
  always @(posedge rclk) begin
    if (rif.ren) rif.rmem_data <= mem[rif.raddr];
  end

  function automatic logic [4:0] gray(input int v);
    logic [4:0] b;
    b = v[4:0];
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  // Make words [wcount, upto) visible to the reader.
  task automatic write_to(input int upto);
    for (int j = wcount; j < upto; j++) mem[j % 16] = wdata[j];
    wcount = upto;
    rif.rq2_wptr = gray(upto);
  endtask

  always @(negedge rclk) begin
    if (mon_en) begin
      check("no_read_when_empty", {31'd0, rif.ren & rif.rempty}, 32'd0);
      check("level_bound", {31'd0, rif.rlevel <= 5'd16}, 32'd1);
      check("empty_vs_level", {31'd0, rif.rempty}, {31'd0, rif.rlevel == 5'd0});
      check("aempty_vs_level", {31'd0, rif.raempty}, {31'd0, rif.rlevel <= 5'd2});
      if (prev_hold) begin
        check("stall_rvalid", {31'd0, rif.rvalid}, 32'd1);
        check("stall_rdata", {24'd0, rif.rdata}, {24'd0, prev_data});
      end
      if (rif.rvalid && rif.rready) begin
        check("data_order", {24'd0, rif.rdata}, {24'd0, wdata[popped]});
        popped++;
      end
      if (rif.rptr == 5'b11000) seen_wrap = 1'b1;
      prev_hold = rif.rvalid && !rif.rready;
      prev_data = rif.rdata;
    end else begin
      prev_hold = 1'b0;
    end
  end

  initial begin
    checks = 0; failures = 0; wcount = 0; popped = 0; seen_wrap = 1'b0;
    mon_en = 1'b0; prev_hold = 1'b0;
    for (int j = 0; j < 256; j++) wdata[j] = 8'($urandom);
    wdata[0] = 8'hA5;
    for (int j = 0; j < 16; j++) mem[j] = 8'h00;

    // Reset
    rrst = 1'b1; rif.rready = 1'b1; rif.rq2_wptr = '0;
    tick(); tick();
    @(negedge rclk);
    check("rst_rempty", {31'd0, rif.rempty}, 32'd1);
    check("rst_raempty", {31'd0, rif.raempty}, 32'd1);
    check("rst_rvalid", {31'd0, rif.rvalid}, 32'd0);
    check("rst_rptr", {27'd0, rif.rptr}, 32'd0);
    check("rst_rlevel", {27'd0, rif.rlevel}, 32'd0);
    check("rst_rdata", {24'd0, rif.rdata}, 32'd0);
    tick();
    rrst = 1'b0; mon_en = 1'b1;

    // Idle with an empty FIFO
    for (int c = 0; c < 10; c++) begin
      @(negedge rclk);
      check("idle_ren", {31'd0, rif.ren}, 32'd0);
      check("idle_rvalid", {31'd0, rif.rvalid}, 32'd0);
      check("idle_rempty", {31'd0, rif.rempty}, 32'd1);
      check("idle_rptr", {27'd0, rif.rptr}, 32'd0);
      tick();
    end

    // Single word: latency from write pointer change to rvalid
    write_to(1);
    @(negedge rclk);
    check("sw_c0_rempty", {31'd0, rif.rempty}, 32'd1);
    check("sw_c0_ren", {31'd0, rif.ren}, 32'd0);
    tick(); @(negedge rclk);
    check("sw_c1_rempty", {31'd0, rif.rempty}, 32'd0);
    check("sw_c1_ren", {31'd0, rif.ren}, 32'd1);
    tick(); @(negedge rclk);
    check("sw_c2_ren", {31'd0, rif.ren}, 32'd0);
    check("sw_c2_rvalid", {31'd0, rif.rvalid}, 32'd0);
    check("sw_c2_rempty", {31'd0, rif.rempty}, 32'd1);
    tick(); @(negedge rclk);
    check("sw_c3_rvalid", {31'd0, rif.rvalid}, 32'd1);
    check("sw_c3_rdata", {24'd0, rif.rdata}, 32'h0000_00A5);
    check("sw_c3_rptr", {27'd0, rif.rptr}, 32'd1);
    tick(); @(negedge rclk);
    check("sw_c4_rvalid", {31'd0, rif.rvalid}, 32'd0);
    tick();

    // Backpressure: five words available, consumer stalled
    rif.rready = 1'b0;
    write_to(6);
    nren = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge rclk);
      if (rif.ren) nren++;
      tick();
    end
    @(negedge rclk);
    check("bp_read_count", nren, 32'd2);
    check("bp_rvalid", {31'd0, rif.rvalid}, 32'd1);
    check("bp_rdata", {24'd0, rif.rdata}, {24'd0, wdata[1]});
    check("bp_rlevel", {27'd0, rif.rlevel}, 32'd3);
    check("bp_raempty", {31'd0, rif.raempty}, 32'd0);
    tick();
    rif.rready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge rclk);
      check("stream_no_gap", {31'd0, rif.rvalid}, 32'd1);
      tick();
    end
    @(negedge rclk);
    check("stream_end_rvalid", {31'd0, rif.rvalid}, 32'd0);
    check("stream_popped", popped, 32'd6);
    tick();

    // Levels and almost-empty
    rif.rready = 1'b0;
    write_to(wcount + 3);
    for (int c = 0; c < 6; c++) tick();
    @(negedge rclk);
    check("lvl_small_rlevel", {27'd0, rif.rlevel}, 32'd1);
    check("lvl_small_raempty", {31'd0, rif.raempty}, 32'd1);
    tick();
    write_to(wcount + 5);
    tick();
    @(negedge rclk);
    check("lvl_big_rlevel", {27'd0, rif.rlevel}, 32'd6);
    check("lvl_big_raempty", {31'd0, rif.raempty}, 32'd0);
    tick();
    rif.rready = 1'b1;
    for (int c = 0; c < 200 && popped < wcount; c++) tick();
    check("lvl_drained", popped, wcount);

    // Random traffic across the pointer wrap
    target = wcount + 40;
    for (int c = 0; c < 3000 && popped < target; c++) begin
      rif.rready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1 && wcount < target) begin
        n = wcount + int'($urandom_range(1, 3));
        if (n > target) n = target;
        if (n > popped + 16) n = popped + 16;
        if (n > wcount) write_to(n);
      end
      tick();
    end
    check("wrap_all_words", popped, target);
    check("wrap_rptr_seen", {31'd0, seen_wrap}, 32'd1);
    rif.rready = 1'b1;
    for (int c = 0; c < 20; c++) tick();

    // Reset while a word is held and another is in flight
    rif.rready = 1'b0;
    write_to(wcount + 4);
    tick(); tick(); tick();
    rrst = 1'b1; mon_en = 1'b0;
    @(negedge rclk);
    check("pre_rst_rvalid", {31'd0, rif.rvalid}, 32'd1);
    tick();
    rrst = 1'b0; rif.rq2_wptr = '0; wcount = 0; popped = 0;
    @(negedge rclk);
    check("mid_rst_rvalid", {31'd0, rif.rvalid}, 32'd0);
    check("mid_rst_rptr", {27'd0, rif.rptr}, 32'd0);
    check("mid_rst_rempty", {31'd0, rif.rempty}, 32'd1);
    check("mid_rst_rlevel", {27'd0, rif.rlevel}, 32'd0);
    tick();
    mon_en = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge rclk);
      check("post_rst_rvalid", {31'd0, rif.rvalid}, 32'd0);
      check("post_rst_ren", {31'd0, rif.ren}, 32'd0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rptr_empty_fwft.md
Name: rptr_empty_fwft

Overview:
Read-side control stage of the asynchronous FIFO, in the read clock domain. It consumes the write pointer after the two-flop synchronizer (rq2_wptr) and owns the read pointer, the empty and almost-empty flags, and a fill-level estimate. It drives the dual-port memory read address and enable, and presents memory data through a 2-entry first-word-fall-through output buffer with a valid/ready handshake.

Parameters:
ADDRSIZE, 4, memory address width; FIFO depth is 2^ADDRSIZE.
DATASIZE, 8, data word width.
AEMPTY_LEVEL, 2, raempty asserts when memory occupancy is at or below this value.

Ports:
rclk  input  1  read-domain clock; all logic on its rising edge.
rrst  input  1  synchronous, active-high reset.
rq2_wptr  input  ADDRSIZE+1  Gray write pointer, already synchronized into rclk.
rptr  output  ADDRSIZE+1  registered Gray read pointer, goes to the write-domain synchronizer.
raddr  output  ADDRSIZE  memory read address = rbin[ADDRSIZE-1:0].
ren  output  1  memory read enable (combinational).
rmem_data  input  DATASIZE  memory read data, valid exactly 1 cycle after ren.
rdata  output  DATASIZE  head-of-buffer data.
rvalid  output  1  rdata valid.
rready  input  1  consumer accepts rdata.
rempty  output  1  registered memory-empty flag.
raempty  output  1  registered almost-empty flag.
rlevel  output  ADDRSIZE+1  registered memory occupancy estimate.

Behaviour:
- Reset, synchronous on rrst=1: rbin=0, rptr=0, rempty=1, raempty=1, rlevel=0, held=0, inflight=0, rvalid=0, rdata=0. A read in flight at reset is discarded, and rmem_data returning on the next cycle is ignored.
- Pointer: rbnext = rbin + ren, with (ADDRSIZE+1)-bit wrap. rgnext = (rbnext>>1) ^ rbnext. rbin<=rbnext and rptr<=rgnext every cycle.
- Empty: rempty <= (rgnext == rq2_wptr). The flag is pessimistic: it deasserts only after the synchronized write pointer moves.
- Output buffer: held (0..2) counts stored entries; inflight (0/1) <= ren. pop = rvalid & rready.
- ren = ~rempty & ((held + inflight - pop) < 2). It must never fire while rempty=1, and the buffer must never overflow.
- When inflight=1, rmem_data is written to the tail entry. The head is shown on rdata. rvalid = (held != 0).
- A capture and a pop in the same cycle leave held unchanged. With held=2 and a pop, the second entry becomes the head in the next cycle.
- Throughput is 1 word per cycle sustained while rready=1 and the memory is non-empty.
- Latency: rq2_wptr moving off empty, then rempty falls 1 cycle later, then ren, then rvalid rises 3 cycles after the rq2_wptr change.
- rdata is stable while rvalid=1 and rready=0.
- Level: wbin_s = gray-to-binary(rq2_wptr). rlevel <= wbin_s - rbnext, mod 2^(ADDRSIZE+1). The count excludes words already in the output buffer.
- raempty <= (wbin_s - rbnext) <= AEMPTY_LEVEL.
- Wrap-around: the pointer MSB toggles every 2^ADDRSIZE reads. Empty is correct across the wrap, and rlevel never exceeds 2^ADDRSIZE.

Test Plan:
- Reset, then hold rq2_wptr=0 and rready=1 for 10 cycles -> rempty=1, raempty=1, ren never asserts, rvalid=0, rptr=0.
- Single word: rq2_wptr goes 0→1 (Gray) at cycle 0, memory word 0xA5 at address 0 -> rempty=0 at cycle 1, ren at cycle 1, rvalid=1 with rdata=0xA5 at cycle 3, then rempty=1 and rptr=1.
- Backpressure: rq2_wptr=Gray(5), rready=0 -> exactly 2 reads issued, held=2, rdata stable on the first word. Then rready=1 -> remaining 3 words stream back-to-back, in order, with no gaps.
- Wrap: push and pop 40 words with random rready, ADDRSIZE=4 -> data order preserved, rptr passes through 0b10000 (bin 16, Gray 11000) correctly, no reads while empty.
- Levels: rq2_wptr=Gray(3), rready=0 -> after 2 reads rlevel=1 and raempty=1. Then rq2_wptr=Gray(8) -> rlevel=6, raempty=0.
- Reset mid-stream with rvalid=1 and inflight=1 -> the next cycle has rvalid=0, rptr=0, rempty=1, and returning data is ignored.
